// File: rtl/track_scorer_if.sv
// Player-facing bus of the tug-of-war scorer: push events and boost map in,
// position display and match status out.
interface track_scorer_if #(
  parameter int STEPS = 3
);
  localparam int unsigned N = 2 * STEPS + 1;

  logic         winrnd;
  logic         right;
  logic         leds_on;
  logic [N-1:0] boost_in;
  logic         new_match;
  logic [N-1:0] score;
  logic [3:0]   left_wins;
  logic [3:0]   right_wins;
  logic         match_over;
  logic         match_right;

  modport master (
    output winrnd, right, leds_on, boost_in, new_match,
    input  score, left_wins, right_wins, match_over, match_right
  );

  modport slave (
    input  winrnd, right, leds_on, boost_in, new_match,
    output score, left_wins, right_wins, match_over, match_right
  );
endinterface

// File: rtl/track_scorer.sv
// Tug-of-war round/match scorer: moves a marker per push, holds round wins
// on display, counts rounds and latches the match winner.
module track_scorer #(
  parameter int STEPS      = 3,
  parameter int HOLD_CYC   = 8,
  parameter int MATCH_WINS = 3
) (
  input  logic           clk,
  input  logic           rst,
  track_scorer_if.slave  bus
);
  localparam int unsigned N  = 2 * STEPS + 1;
  localparam int unsigned PW = $clog2(STEPS + 2) + 1;
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = 8;
  localparam int          W  = STEPS + 1;
  localparam logic [N-1:0] NEUTRAL = N'(1) << STEPS;

  localparam logic [1:0] PLAY       = 2'd0;
  localparam logic [1:0] HOLD       = 2'd1;
  localparam logic [1:0] MATCH_OVER = 2'd2;

  logic [1:0]           state, state_n;
  logic signed [PW-1:0] pos, pos_n;
  logic [N-1:0]         boost_q, boost_n;
  logic [CW-1:0]        hold_cnt, hold_n;
  logic [3:0]           lw, lw_n, rw, rw_n;
  logic [N-1:0]         score_q, score_n;
  logic                 mo_q, mo_n, mr_q, mr_n;

  int                   p, np, step;
  logic                 mv;
  logic [IW-1:0]        bidx;
  logic [3:0]           win_cnt;

  // Display pattern for a position: one-hot in play, filled half at a win.
  function automatic logic [N-1:0] decode(input int pp);
    logic [N-1:0] s;
    s = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (pp == W)                              s[i] = (i < STEPS);
      else if (pp == -W)                        s[i] = (i > STEPS);
      else if (pp >= -STEPS && pp <= STEPS)     s[i] = (i == STEPS - pp);
    end
    return s;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= PLAY;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    pos_n   = pos;
    boost_n = boost_q;
    hold_n  = hold_cnt;
    lw_n    = lw;
    rw_n    = rw;
    mr_n    = mr_q;
    p       = int'(pos);
    np      = p;
    step    = 1;
    mv      = 1'b0;
    bidx    = '0;
    win_cnt = '0;

    case (state)
      PLAY: begin
        if (p == 0) boost_n = bus.boost_in;
        if (bus.new_match) begin
          lw_n = '0;
          rw_n = '0;
        end
        if (bus.winrnd) begin
          // A foul moves the marker toward the opponent's side, never boosted.
          mv   = (bus.right & bus.leds_on) | (~bus.right & ~bus.leds_on);
          bidx = IW'(STEPS - p);
          step = (bus.leds_on && boost_q[bidx]) ? 2 : 1;
          np   = mv ? p + step : p - step;
          if (np > W)  np = W;
          if (np < -W) np = -W;
          pos_n = PW'(np);
          if (np == W) begin
            state_n = HOLD;
            hold_n  = '0;
            rw_n    = rw_n + 4'd1;
          end else if (np == -W) begin
            state_n = HOLD;
            hold_n  = '0;
            lw_n    = lw_n + 4'd1;
          end
        end
      end
      HOLD: begin
        if (bus.new_match) begin
          lw_n = '0;
          rw_n = '0;
        end
        win_cnt = (p > 0) ? rw_n : lw_n;
        if (hold_cnt == CW'(HOLD_CYC - 1)) begin
          if (win_cnt == 4'(MATCH_WINS)) begin
            state_n = MATCH_OVER;
            mr_n    = (p > 0);
          end else begin
            state_n = PLAY;
            pos_n   = '0;
          end
        end else begin
          hold_n = hold_cnt + CW'(1);
        end
      end
      MATCH_OVER: begin
        if (bus.new_match) begin
          lw_n    = '0;
          rw_n    = '0;
          pos_n   = '0;
          mr_n    = 1'b0;
          state_n = PLAY;
        end
      end
      default: begin
        state_n = PLAY;
        pos_n   = '0;
      end
    endcase

    score_n = decode(int'(pos_n));
    mo_n    = (state_n == MATCH_OVER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos      <= '0;
      boost_q  <= '0;
      hold_cnt <= '0;
      lw       <= '0;
      rw       <= '0;
      score_q  <= NEUTRAL;
      mo_q     <= 1'b0;
      mr_q     <= 1'b0;
    end else begin
      pos      <= pos_n;
      boost_q  <= boost_n;
      hold_cnt <= hold_n;
      lw       <= lw_n;
      rw       <= rw_n;
      score_q  <= score_n;
      mo_q     <= mo_n;
      mr_q     <= mr_n;
    end
  end

  assign bus.score       = score_q;
  assign bus.left_wins   = lw;
  assign bus.right_wins  = rw;
  assign bus.match_over  = mo_q;
  assign bus.match_right = mr_q;
endmodule

// File: tb/tb_track_scorer.sv
// Directed scoreboard bench for track_scorer (STEPS=3, HOLD_CYC=8, MATCH_WINS=3).
module tb_track_scorer;
  logic clk;
  logic rst;

  track_scorer_if #(.STEPS(3)) bus ();

  track_scorer #(.STEPS(3), .HOLD_CYC(8), .MATCH_WINS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [6:0] sc;
    logic [3:0] lw;
    logic [3:0] rw;
    logic       mo;
    logic       mr;
    string      name;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected entry per cycle, compared away from the active edge.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      if (bus.score !== e.sc || bus.left_wins !== e.lw || bus.right_wins !== e.rw ||
          bus.match_over !== e.mo || bus.match_right !== e.mr) begin
        errors++;
        $display("FAIL %s: got score=%b lw=%0d rw=%0d mo=%b mr=%b, want score=%b lw=%0d rw=%0d mo=%b mr=%b",
                 e.name, bus.score, bus.left_wins, bus.right_wins, bus.match_over, bus.match_right,
                 e.sc, e.lw, e.rw, e.mo, e.mr);
      end
    end
  end

  task automatic push_exp(input logic [6:0] es, input logic [3:0] elw, input logic [3:0] erw,
                          input logic emo, input logic emr, input string nm);
    exp_t x;
    x.sc = es; x.lw = elw; x.rw = erw; x.mo = emo; x.mr = emr; x.name = nm;
    q.push_back(x);
  endtask

  task automatic cyc(input logic w, input logic r, input logic l, input logic nmt,
                     input logic [6:0] es, input logic [3:0] elw, input logic [3:0] erw,
                     input logic emo, input logic emr, input string nm);
    bus.winrnd    = w;
    bus.right     = r;
    bus.leds_on   = l;
    bus.new_match = nmt;
    @(posedge clk);
    #1;
    push_exp(es, elw, erw, emo, emr, nm);
    bus.winrnd    = 1'b0;
    bus.new_match = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.winrnd = 1'b0; bus.right = 1'b0; bus.leds_on = 1'b0;
    bus.new_match = 1'b0; bus.boost_in = 7'b0;
    rst = 1'b1;
    push_exp(7'b0001000, 4'd0, 4'd0, 1'b0, 1'b0, "reset");
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Right walks to a round win.
    cyc(1, 1, 1, 0, 7'b0000100, 0, 0, 0, 0, "r1");
    cyc(1, 1, 1, 0, 7'b0000010, 0, 0, 0, 0, "r2");
    cyc(1, 1, 1, 0, 7'b0000001, 0, 0, 0, 0, "r3");
    cyc(1, 1, 1, 0, 7'b0000111, 0, 1, 0, 0, "rwin");
    for (int i = 0; i < 7; i++) cyc(1, 0, 1, 0, 7'b0000111, 0, 1, 0, 0, "hold_ignore");
    cyc(1, 0, 1, 0, 7'b0001000, 0, 1, 0, 0, "hold_end");

    // Fouls move the other way and never double-step.
    bus.boost_in = 7'h7F;
    cyc(0, 0, 0, 0, 7'b0001000, 0, 1, 0, 0, "latch_ones");
    cyc(1, 0, 0, 0, 7'b0000100, 0, 1, 0, 0, "foul_left");
    cyc(1, 1, 0, 0, 7'b0001000, 0, 1, 0, 0, "foul_right");
    cyc(1, 0, 1, 0, 7'b0100000, 0, 1, 0, 0, "boost_left");
    bus.boost_in = 7'b0;
    cyc(1, 1, 0, 0, 7'b1000000, 0, 1, 0, 0, "foul_right2");
    cyc(1, 0, 1, 0, 7'b1110000, 1, 1, 0, 0, "lwin_saturate");
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 7'b1110000, 1, 1, 0, 0, "hold2");
    cyc(0, 0, 0, 0, 7'b0001000, 1, 1, 0, 0, "hold2_end");

    // Boost latched only at neutral, frozen elsewhere.
    bus.boost_in = 7'b0001000;
    cyc(0, 0, 0, 0, 7'b0001000, 1, 1, 0, 0, "latch_mid");
    cyc(1, 1, 1, 0, 7'b0000010, 1, 1, 0, 0, "boost_right");
    bus.boost_in = 7'h7F;
    cyc(1, 1, 1, 0, 7'b0000001, 1, 1, 0, 0, "boost_frozen");
    cyc(1, 0, 1, 0, 7'b0000010, 1, 1, 0, 0, "back1");
    cyc(1, 0, 1, 0, 7'b0000100, 1, 1, 0, 0, "back2");
    cyc(1, 0, 1, 0, 7'b0001000, 1, 1, 0, 0, "back3");
    bus.boost_in = 7'b0;
    cyc(0, 0, 0, 0, 7'b0001000, 1, 1, 0, 0, "latch_zero");

    // new_match during play and hold.
    cyc(1, 1, 1, 1, 7'b0000100, 0, 0, 0, 0, "nm_with_move");
    cyc(1, 1, 1, 0, 7'b0000010, 0, 0, 0, 0, "nm_r2");
    cyc(1, 1, 1, 0, 7'b0000001, 0, 0, 0, 0, "nm_r3");
    cyc(1, 1, 1, 1, 7'b0000111, 0, 1, 0, 0, "nm_with_win");
    cyc(0, 0, 0, 1, 7'b0000111, 0, 0, 0, 0, "nm_in_hold");
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 7'b0000111, 0, 0, 0, 0, "hold3");
    cyc(0, 0, 0, 0, 7'b0001000, 0, 0, 0, 0, "hold3_end");

    // Left takes the match in three rounds.
    for (int k = 1; k <= 3; k++) begin
      cyc(1, 0, 1, 0, 7'b0010000, 4'(k - 1), 0, 0, 0, "m_l1");
      cyc(1, 0, 1, 0, 7'b0100000, 4'(k - 1), 0, 0, 0, "m_l2");
      cyc(1, 0, 1, 0, 7'b1000000, 4'(k - 1), 0, 0, 0, "m_l3");
      cyc(1, 0, 1, 0, 7'b1110000, 4'(k), 0, 0, 0, "m_lwin");
      for (int i = 0; i < 7; i++) cyc(1, 1, 1, 0, 7'b1110000, 4'(k), 0, 0, 0, "m_hold");
      if (k < 3) cyc(0, 0, 0, 0, 7'b0001000, 4'(k), 0, 0, 0, "m_hold_end");
      else       cyc(0, 0, 0, 0, 7'b1110000, 4'(k), 0, 1, 0, "match_over");
    end
    cyc(1, 1, 1, 0, 7'b1110000, 3, 0, 1, 0, "mo_ignore1");
    cyc(1, 0, 0, 0, 7'b1110000, 3, 0, 1, 0, "mo_ignore2");
    cyc(0, 0, 0, 1, 7'b0001000, 0, 0, 0, 0, "new_match");

    // Right wins two rounds, then reset strikes mid-hold.
    for (int k = 1; k <= 2; k++) begin
      cyc(1, 1, 1, 0, 7'b0000100, 0, 4'(k - 1), 0, 0, "f_r1");
      cyc(1, 1, 1, 0, 7'b0000010, 0, 4'(k - 1), 0, 0, "f_r2");
      cyc(1, 1, 1, 0, 7'b0000001, 0, 4'(k - 1), 0, 0, "f_r3");
      cyc(1, 1, 1, 0, 7'b0000111, 0, 4'(k), 0, 0, "f_rwin");
      if (k == 1) begin
        for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 7'b0000111, 0, 1, 0, 0, "f_hold");
        cyc(0, 0, 0, 0, 7'b0001000, 0, 1, 0, 0, "f_hold_end");
      end
    end
    cyc(0, 0, 0, 0, 7'b0000111, 0, 2, 0, 0, "f_hold2a");
    cyc(0, 0, 0, 0, 7'b0000111, 0, 2, 0, 0, "f_hold2b");
    @(negedge clk);
    #1 rst = 1'b1;
    push_exp(7'b0001000, 4'd0, 4'd0, 1'b0, 1'b0, "rst_mid_hold");
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    cyc(1, 1, 1, 0, 7'b0000100, 0, 0, 0, 0, "post_rst_push");

    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries never compared, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/track_scorer.md
TRACK_SCORER -- requirements
Module: track_scorer

Interface
REQ-001 Parameter STEPS, default 3: positions per side between neutral and the win position; legal range 1..7.
REQ-002 Parameter HOLD_CYC, default 8: cycles a round win is displayed before auto-return to neutral; legal range 1..255.
REQ-003 Parameter MATCH_WINS, default 3: round wins needed to take the match; legal range 1..15.
REQ-004 clk  in  1  system clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 winrnd  in  1  one-cycle pulse: a player has pushed.
REQ-007 right  in  1  qualifies winrnd: 1 = right player pushed first, 0 = left.
REQ-008 leds_on  in  1  qualifies winrnd: 1 = proper push, 0 = jumped the light.
REQ-009 boost_in  in  2*STEPS+1  per-position double-step enables, indexed like score.
REQ-010 new_match  in  1  pulse: clears round counters and leaves MATCH_OVER.
REQ-011 score  out  2*STEPS+1  display vector; MSB = L_STEPS, bit STEPS = neutral, bit 0 = R_STEPS.
REQ-012 left_wins, right_wins  out  4 each  round wins in the current match.
REQ-013 match_over  out  1  high while in MATCH_OVER.
REQ-014 match_right  out  1  match winner (1 = right); valid only while match_over = 1.

Function
REQ-015 Position pos is a signed value in -(STEPS+1)..+(STEPS+1); 0 = neutral, +(STEPS+1) = right round win, -(STEPS+1) = left round win.
REQ-016 In PLAY, score is one-hot with bit (STEPS - pos) set.
REQ-017 At a right round win, score[STEPS-1:0] = all ones and all other bits = 0; at a left round win, score[2*STEPS:STEPS+1] = all ones and all other bits = 0.
REQ-018 Movement direction: mr = (right & leds_on) | (~right & ~leds_on); mr = 1 moves pos +, mr = 0 moves pos -.
REQ-019 Proper push (leds_on = 1): step = 2 when the latched boost bit at the current position is 1, else step = 1.
REQ-020 Foul push (leds_on = 0): step is always 1, and boost does not apply.
REQ-021 Moves saturate at +/-(STEPS+1); a double step from +/-STEPS lands on the win position.
REQ-022 boost_in is latched into an internal register on every cycle in which pos = 0 and state = PLAY; it is frozen while pos != 0.
REQ-023 The state machine has three states: PLAY, HOLD and MATCH_OVER.
REQ-024 PLAY -> HOLD on the cycle in which pos reaches +/-(STEPS+1); the winner's counter increments on that same edge.
REQ-025 HOLD lasts exactly HOLD_CYC cycles, then moves to PLAY with pos = 0, unless the incremented counter equals MATCH_WINS, in which case it moves to MATCH_OVER.
REQ-026 winrnd is ignored in HOLD and MATCH_OVER, and no movement occurs.
REQ-027 MATCH_OVER holds the winning display pattern and sets match_right.
REQ-028 new_match in MATCH_OVER: clears both counters, sets pos = 0, and goes to PLAY on the next edge.
REQ-029 new_match in PLAY or HOLD: clears both counters only; state and pos are unchanged.
REQ-030 When winrnd and new_match are asserted in the same cycle in PLAY, both take effect: the counters clear and the move applies.
REQ-031 The winning move itself still lands even if new_match is asserted; the counter then increments from 0 to 1.
REQ-032 Outputs are registered or decoded from registers only; the block has no combinational path from inputs to outputs.
REQ-033 An out-of-range internal position shall never be produced; the score decode default is all zeros.

Reset
REQ-034 On rst, outputs take these values asynchronously: state = PLAY, pos = 0, score = one-hot neutral (bit STEPS), left_wins = right_wins = 0, match_over = 0, match_right = 0, boost register = 0.
REQ-035 rst asserted mid-HOLD or in MATCH_OVER aborts immediately to the reset values; no pending increment survives.
REQ-036 The first winrnd honoured after reset is the first one sampled on a rising edge after rst deasserts.

Verification
REQ-037 STEPS=3, boost=0: three right proper pushes -> score 0001000, 0000100, 0000010, 0000001; fourth push -> 0000111 and right_wins = 1.
REQ-038 From pos 0: left push with leds_on = 0 -> score 0000100 (right moves); foul with boost_in = all ones -> single step only.
REQ-039 boost_in = 7'b0001000 latched at neutral, then right proper push -> score 0000010; change boost_in afterwards -> no effect until pos returns to 0.
REQ-040 HOLD_CYC = 8: after a win, winrnd pulses during the next 8 cycles are ignored; cycle 9 shows score 0001000.
REQ-041 MATCH_WINS = 3: left wins three rounds -> match_over = 1, match_right = 0, score 1110000, further winrnd ignored; new_match -> PLAY, counters 0.
REQ-042 rst pulsed mid-HOLD with right_wins = 2 -> immediate neutral display, counters 0, match_over = 0.
